// File: rtl/stream_mux_rr.sv
// Channel multiplexer for valid/ready streams with a one-deep registered output stage.
// The source is either picked directly by sel or by round-robin arbitration starting at ptr.
module stream_mux_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic                  load_en;
  logic                  grant_vld;
  logic [SEL_W-1:0]      grant;
  logic [SEL_W-1:0]      ptr;
  logic [WIDTH-1:0]      grant_data;
  logic [2*CHANNELS-1:0] req2;
  int                    off;
  int                    sum;

  assign load_en = !out_valid || out_ready;

  // Round-robin: rotate the requests so bit 0 is ptr, take the lowest set bit, rotate back.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    req2      = '0;
    off       = 0;
    sum       = 0;
    if (!mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant_vld = 1'b1;
          grant     = SEL_W'(i);
        end
      end
    end else begin
      req2 = {in_valid, in_valid} >> ptr;
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        if (req2[k]) begin
          grant_vld = 1'b1;
          off       = k;
        end
      end
      sum = int'(ptr) + off;
      if (sum >= CHANNELS) begin
        sum = sum - CHANNELS;
      end
      grant = SEL_W'(sum);
    end
  end

  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant == SEL_W'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
      in_ready[i] = !rst && load_en && grant_vld && (grant == SEL_W'(i));
    end
  end

  // A granted beat replaces the register; with nothing granted the stage drains but keeps data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      if (grant_vld) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_chan  <= grant;
        if (mode) begin
          ptr <= (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + 1'b1;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: expected beats are queued when a grant is expected
// and popped when the output hands off; a 3-channel instance checks out-of-range sel.
module tb_stream_mux_rr;

  typedef struct packed {
    logic [1:0] chan;
    logic [7:0] data;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  logic        mode3;
  logic [1:0]  sel3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_chan3;
  logic        out_valid3;
  logic        out_ready3;

  beat_t sb[$];
  int    tests;
  int    failures;

  stream_mux_rr #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  stream_mux_rr #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic m, input logic [1:0] s, input logic [3:0] v,
                               input logic [31:0] d, input logic ordy);
    mode      = m;
    sel       = s;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic checkOutput(input logic [3:0] exp_rdy, input string tag);
    beat_t b;
    @(negedge clk);
    check({tag, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check({tag, " unexpected beat"}, 32'(out_valid), 32'd0);
      end else begin
        b = sb.pop_front();
        check({tag, " out_chan"}, 32'(out_chan), 32'(b.chan));
        check({tag, " out_data"}, 32'(out_data), 32'(b.data));
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (exp_rdy[i]) begin
        b.chan = 2'(i);
        b.data = in_data[i*8 +: 8];
        sb.push_back(b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests      = 0;
    failures   = 0;
    rst        = 1'b1;
    applyStimulus(1'b0, 2'd2, 4'hF, 32'h0, 1'b1);
    mode3      = 1'b0;
    sel3       = 2'd3;
    in_valid3  = 3'b111;
    in_data3   = 24'h332211;
    out_ready3 = 1'b1;

    #12;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset out_chan", 32'(out_chan), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 2'd2, 4'hF, 32'h44A52233, 1'b1);
      checkOutput(4'b0100, "fixed");
    end

    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 2'd0, 4'hF,
                    {8'(k*4+3), 8'(k*4+2), 8'(k*4+1), 8'(k*4)}, 1'b1);
      checkOutput(4'(1 << (k % 4)), "rr_fair");
    end

    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 2'd0, 4'b1010, {8'(8'h80 + k), 8'h00, 8'(8'h90 + k), 8'h00}, 1'b1);
      checkOutput((k % 2 == 0) ? 4'b0010 : 4'b1000, "rr_alt");
    end

    applyStimulus(1'b0, 2'd3, 4'b1000, 32'h3C000000, 1'b1);
    checkOutput(4'b1000, "bp_load");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 2'd3, 4'hF, 32'h77665544, 1'b0);
      checkOutput(4'b0000, "bp_stall");
      check("bp_stall out_valid", 32'(out_valid), 32'd1);
      check("bp_stall out_data", 32'(out_data), 32'h3C);
      check("bp_stall out_chan", 32'(out_chan), 32'd3);
    end
    applyStimulus(1'b0, 2'd3, 4'hF, 32'h77665544, 1'b1);
    checkOutput(4'b1000, "bp_release");

    applyStimulus(1'b0, 2'd1, 4'b1101, 32'h0, 1'b1);
    checkOutput(4'b0000, "drain");
    check("drain out_valid", 32'(out_valid), 32'd0);
    check("drain out_data hold", 32'(out_data), 32'h77);
    check("ch3 sel3 in_ready", 32'(in_ready3), 32'd0);
    check("ch3 sel3 out_valid", 32'(out_valid3), 32'd0);
    check("ch3 sel3 out_data", 32'(out_data3), 32'd0);
    check("ch3 sel3 out_chan", 32'(out_chan3), 32'd0);
    checkOutput(4'b0000, "drain_idle");

    applyStimulus(1'b1, 2'd0, 4'b0010, 32'h00005A00, 1'b1);
    checkOutput(4'b0010, "ms_rr1");
    applyStimulus(1'b0, 2'd0, 4'hF, 32'h000000C1, 1'b1);
    checkOutput(4'b0001, "ms_fix");
    applyStimulus(1'b0, 2'd0, 4'hF, 32'h000000C2, 1'b1);
    checkOutput(4'b0001, "ms_fix");
    applyStimulus(1'b1, 2'd0, 4'hF, 32'hD3D2D1D0, 1'b1);
    checkOutput(4'b0100, "ms_rr2");

    applyStimulus(1'b1, 2'd0, 4'b0010, 32'h0000E100, 1'b1);
    checkOutput(4'b0010, "pre_reset");
    rst = 1'b1;
    #1;
    check("midreset out_valid", 32'(out_valid), 32'd0);
    check("midreset out_data", 32'(out_data), 32'd0);
    check("midreset out_chan", 32'(out_chan), 32'd0);
    check("midreset in_ready", 32'(in_ready), 32'd0);
    check("midreset ch3 in_ready", 32'(in_ready3), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;

    applyStimulus(1'b1, 2'd0, 4'hF, 32'hF3F2F1F0, 1'b1);
    checkOutput(4'b0001, "post_reset");
    applyStimulus(1'b1, 2'd0, 4'h0, 32'h0, 1'b1);
    checkOutput(4'b0000, "final_drain");
    check("ch3 sel3 never valid", 32'(out_valid3), 32'd0);
    check("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised successor to the team's 2:1 gate-level mux.
- Selects one of CHANNELS input streams, each WIDTH bits wide, and forwards it through a one-deep registered output stage.
- Uses valid/ready handshakes on every input and on the output.
- Two selection modes: fixed select (driven by sel) and round-robin arbitration.
- Sits between multiple producers and a single shared consumer.

Parameters:
- WIDTH, 8, data bits per channel
- CHANNELS, 4, number of input channels (>=2)
- SEL_W, 2, select/channel-index width; must equal clog2(CHANNELS)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- mode  input  1  0 = fixed select by sel, 1 = round-robin
- sel  input  SEL_W  channel index used when mode=0
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel valid
- in_ready  output  CHANNELS  per-channel ready (combinational)
- out_data  output  WIDTH  registered data
- out_chan  output  SEL_W  registered index of the source channel
- out_valid  output  1  registered valid
- out_ready  input  1  consumer ready

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_chan=0, round-robin pointer ptr=0. All in_ready are 0 while rst=1.
- Load enable: load_en = !out_valid || out_ready. This gives full throughput, one transfer per cycle.
- Grant when mode=0:
  - grant = sel if sel < CHANNELS and in_valid[sel]=1.
  - Otherwise no grant.
  - sel >= CHANNELS means no grant ever.
- Grant when mode=1:
  - Scan channels ptr, ptr+1, ... modulo CHANNELS.
  - The first i with in_valid[i]=1 is granted.
  - If no input is valid, there is no grant.
- in_ready[i] = load_en && grant valid && (grant == i). At most one in_ready bit is high. in_ready never depends on a registered copy of in_valid.
- Input transfer on channel i = in_valid[i] && in_ready[i].
- On a transfer on channel g, at the next clock edge:
  - out_data <= in_data[g]
  - out_chan <= g
  - out_valid <= 1
  - ptr <= (g == CHANNELS-1) ? 0 : g+1
- ptr updates only on a transfer, and only when mode=1. In mode=0, ptr holds its value.
- If load_en=1 and there is no grant: out_valid <= 0. out_data and out_chan hold their values.
- If load_en=0 (out_valid=1, out_ready=0): out_data, out_chan and out_valid hold. All in_ready are 0. Data stays stable while stalled.
- Latency: exactly 1 cycle from the input transfer edge to out_valid=1.
- Simultaneous output transfer and new grant in the same cycle: the register is replaced by the new beat, and out_valid stays 1 (back-to-back).
- Mode or sel changes take effect on the same cycle's grant computation. A beat already in the output register is unaffected. ptr is preserved across mode switches.
- Reset asserted mid-stream: the output register is cleared immediately (asynchronously) and the in-flight beat is dropped. After reset deasserts, the first grant uses ptr=0.
- Fairness: in mode 1, with all channels continuously valid and out_ready=1, grants rotate 0,1,...,CHANNELS-1,0,...

Test Plan:
1. Reset: drive rst=1 mid-transfer with out_valid=1 -> out_valid=0, out_data=0, out_chan=0 asynchronously, before the next clock edge; all in_ready=0.
2. Fixed select, back-to-back: mode=0, sel=2, in_valid=4'b1111, channel 2 data=8'hA5, out_ready=1 -> in_ready=4'b0100. One cycle later out_data=8'hA5, out_chan=2, out_valid=1, sustained every cycle.
3. Round-robin fairness: mode=1, in_valid=4'b1111, out_ready=1 held for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3. Then in_valid=4'b1010 -> out_chan alternates 1,3.
4. Backpressure: beat 8'h3C registered, out_ready=0 for 3 cycles -> out_data=8'h3C and out_valid=1 held, in_ready=4'b0000. Release out_ready -> next beat loads in the same cycle as the handoff.
5. No-grant drain: mode=0, sel=1, in_valid=4'b1101, out_valid=1, out_ready=1 -> next cycle out_valid=0, in_ready=0. Also check CHANNELS=3 with sel=3 -> no grant ever.
6. Mode switch: from mode=1 after a grant to channel 1 (ptr=2), switch to mode=0 with sel=0 for 2 beats, then back to mode=1 with all channels valid -> the first round-robin grant is channel 2.
